// File: rtl/aexm_pkg.sv
// Shared opcode constants and decode helpers for the aexm pipeline.
package aexm_pkg;

   localparam logic [5:0] OPC_NOP  = 6'o40;
   localparam logic [5:0] OPC_IMM  = 6'o54;
   localparam logic [5:0] OPC_RTD  = 6'o55;
   localparam logic [5:0] OPC_BRU  = 6'o46;
   localparam logic [5:0] OPC_BRUI = 6'o56;
   localparam logic [5:0] OPC_BCC  = 6'o47;
   localparam logic [5:0] OPC_BCCI = 6'o57;

   localparam logic [1:0] MXALT_REG = 2'd0;
   localparam logic [1:0] MXALT_ALU = 2'd1;
   localparam logic [1:0] MXALT_LD  = 2'd2;

   localparam logic [31:0] INT_VEC = 32'h0000_0010;

   function automatic logic is_branch(input logic [5:0] opc);
      return (opc == OPC_BRU) || (opc == OPC_BRUI) || (opc == OPC_BCC) || (opc == OPC_BCCI);
   endfunction

   function automatic logic is_load(input logic [5:0] opc);
      return (opc[5:4] == 2'b11) && !opc[2];
   endfunction

   function automatic logic is_store(input logic [5:0] opc);
      return (opc[5:4] == 2'b11) && opc[2];
   endfunction

   // RA source select given the instruction currently in decode and the new RA.
   function automatic logic [1:0] fwd_sel(input logic [5:0] prev_opc,
                                          input logic [4:0] prev_rd,
                                          input logic [4:0] new_ra);
      logic [1:0] sel;
      sel = MXALT_REG;
      if ((prev_rd == new_ra) && (new_ra != 5'd0)) begin
         if (is_load(prev_opc)) begin
            sel = MXALT_LD;
         end else if (!is_branch(prev_opc) && !is_store(prev_opc) && (prev_opc != OPC_IMM)) begin
            sel = MXALT_ALU;
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/aexm_intsync.sv
// Interrupt request synchronizer, rising-edge detector and pending latch.
// Only instantiated when AEXM_INTERRUPT_EN is defined.
module aexm_intsync
   import aexm_pkg::*;
(
   input  logic gclk,
   input  logic grst,
   input  logic gena,
   input  logic irq_async,
   input  logic ack,
   output logic rINTP
);

   logic sync1, sync2, sync3;
   logic rise;

   // Edge of the synchronized request; a new edge beats a same-cycle ack.
   always_comb begin
      rise = sync2 & ~sync3;
   end

   // Two-flop synchronizer, edge history flop and pending latch.
   always_ff @(posedge gclk) begin
      if (grst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
         rINTP <= 1'b0;
      end else if (gena) begin
         sync1 <= irq_async;
         sync2 <= sync1;
         sync3 <= sync2;
         if (rise)     rINTP <= 1'b1;
         else if (ack) rINTP <= 1'b0;
      end
   end

endmodule

// File: rtl/aexm_ibuf.sv
// Instruction buffer / decode latch. Splits the fetched word into fields,
// merges imm prefixes, squashes skipped slots and computes the RA forward select.
// Optional interrupt-branch injection is enabled by defining AEXM_INTERRUPT_EN.
module aexm_ibuf
   import aexm_pkg::*;
(
   input  logic        gclk,
   input  logic        grst,
   input  logic        gena,
   input  logic [31:0] aexm_icache_datao,
   input  logic        rSKIP,
`ifdef AEXM_INTERRUPT_EN
   input  logic        sys_int_i,
   input  logic        rMSR_IE,
`endif
   output logic [5:0]  rOPC,
   output logic [4:0]  rRD,
   output logic [4:0]  rRA,
   output logic [4:0]  rRB,
   output logic [10:0] rALT,
   output logic [31:0] rSIMM,
   output logic [1:0]  rMXALT,
   output logic        rINTACK
);

   logic [15:0] rIMMHI;
   logic        rIMMVLD;

   logic [5:0]  opc_d;
   logic [4:0]  rd_d, ra_d, rb_d;
   logic [10:0] alt_d;
   logic [31:0] simm_d;
   logic [1:0]  mxalt_d;
   logic [15:0] immhi_d;
   logic        immvld_d;
   logic        inject;

   logic [5:0]  w_opc;
   logic [15:0] w_imm;

   assign w_opc = aexm_icache_datao[31:26];
   assign w_imm = aexm_icache_datao[15:0];

`ifdef AEXM_INTERRUPT_EN
   logic rINTP;

   aexm_intsync u_intsync (
      .gclk      (gclk),
      .grst      (grst),
      .gena      (gena),
      .irq_async (sys_int_i),
      .ack       (inject),
      .rINTP     (rINTP)
   );

   // Never inject inside an imm/instruction pair or behind a control transfer.
   always_comb begin
      inject = rINTP & rMSR_IE & ~rSKIP & ~rIMMVLD &
               ~(is_branch(rOPC) | (rOPC == OPC_RTD) | (rOPC == OPC_IMM));
   end

   // Acknowledge pulse lasts exactly one enabled cycle.
   always_ff @(posedge gclk) begin
      if (grst)      rINTACK <= 1'b0;
      else if (gena) rINTACK <= inject;
   end
`else
   assign inject  = 1'b0;
   assign rINTACK = 1'b0;
`endif

   // Next decode state: injected branch, squashed NOP, or the fetched word.
   always_comb begin
      opc_d    = w_opc;
      rd_d     = aexm_icache_datao[25:21];
      ra_d     = aexm_icache_datao[20:16];
      rb_d     = aexm_icache_datao[15:11];
      alt_d    = aexm_icache_datao[10:0];
      simm_d   = rIMMVLD ? {rIMMHI, w_imm} : {{16{w_imm[15]}}, w_imm};
      mxalt_d  = fwd_sel(rOPC, rRD, aexm_icache_datao[20:16]);
      immvld_d = (w_opc == OPC_IMM);
      immhi_d  = (w_opc == OPC_IMM) ? w_imm : rIMMHI;
      if (inject) begin
         // brali r14,0x10
         opc_d    = OPC_BRUI;
         rd_d     = 5'd14;
         ra_d     = 5'b01100;
         rb_d     = INT_VEC[15:11];
         alt_d    = INT_VEC[10:0];
         simm_d   = INT_VEC;
         mxalt_d  = MXALT_REG;
         immvld_d = 1'b0;
         immhi_d  = rIMMHI;
      end else if (rSKIP) begin
         opc_d    = OPC_NOP;
         rd_d     = 5'd0;
         ra_d     = 5'd0;
         rb_d     = 5'd0;
         alt_d    = 11'd0;
         simm_d   = 32'd0;
         mxalt_d  = MXALT_REG;
         immvld_d = 1'b0;
         immhi_d  = rIMMHI;
      end
   end

   // Decode latch; reset overrides gena, gena=0 freezes everything.
   always_ff @(posedge gclk) begin
      if (grst) begin
         rOPC    <= OPC_NOP;
         rRD     <= 5'd0;
         rRA     <= 5'd0;
         rRB     <= 5'd0;
         rALT    <= 11'd0;
         rSIMM   <= 32'd0;
         rMXALT  <= MXALT_REG;
         rIMMHI  <= 16'd0;
         rIMMVLD <= 1'b0;
      end else if (gena) begin
         rOPC    <= opc_d;
         rRD     <= rd_d;
         rRA     <= ra_d;
         rRB     <= rb_d;
         rALT    <= alt_d;
         rSIMM   <= simm_d;
         rMXALT  <= mxalt_d;
         rIMMHI  <= immhi_d;
         rIMMVLD <= immvld_d;
      end
   end

endmodule
